// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm sequencer: state encodings,
// status LED colours and the state_code width.
package alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_DISARMED    = 3'd0,
        ST_EXIT_DELAY  = 3'd1,
        ST_ARMED       = 3'd2,
        ST_ENTRY_DELAY = 3'd3,
        ST_ALARM       = 3'd4
    } state_e;

    // LED colours are packed {R,G,B}
    localparam logic [2:0] LED_GREEN   = 3'b010;
    localparam logic [2:0] LED_YELLOW  = 3'b110;
    localparam logic [2:0] LED_RED     = 3'b100;
    localparam logic [2:0] LED_MAGENTA = 3'b101;

    // Status LED colour shown while in a given state
    function automatic logic [2:0] led_for_state(input state_e s);
        logic [2:0] led;
        case (s)
            ST_DISARMED:    led = LED_GREEN;
            ST_EXIT_DELAY:  led = LED_YELLOW;
            ST_ARMED:       led = LED_RED;
            ST_ENTRY_DELAY: led = LED_RED;
            ST_ALARM:       led = LED_MAGENTA;
            default:        led = LED_GREEN;
        endcase
        return led;
    endfunction

endpackage

// File: rtl/alarm_sequencer_tick_prescaler.sv
// Free-running tick prescaler: counts 0..CLK_PER_TICK-1 while enabled and
// pulses tick for one cycle on the last count. clear restarts the count so
// the first tick lands exactly CLK_PER_TICK cycles after a state entry.
module tick_prescaler #(
    parameter int CLK_PER_TICK = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int PW = (CLK_PER_TICK > 2) ? $clog2(CLK_PER_TICK) : 1;
    localparam logic [PW-1:0] LAST = PW'(CLK_PER_TICK - 1);

    if (CLK_PER_TICK < 2) begin : g_chk_cpt
        $error("tick_prescaler: CLK_PER_TICK must be >= 2");
    end

    logic [PW-1:0] cnt_q;
    logic [PW-1:0] cnt_d;

    // tick must not depend on clear: clear is derived from the next state,
    // which itself depends on tick
    assign tick = enable && (cnt_q == LAST);

    // Next count: restart on clear, wrap at the last count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alarm_sequencer.sv
// Arm/disarm controller for the home security system. Sequences exit delay,
// entry delay, alarm and alarm timeout off a prescaled tick, and drives the
// buzzer, status LED, display state code and remaining-tick countdown.
// Both inputs are registered before use, so an input sampled at one edge
// acts on state at the following edge.
// Build option: define ALARM_LATCH_EN to make ALARM latch until a button
// press (no timeout, countdown held at 0).
module alarm_sequencer
    import alarm_pkg::*;
#(
    parameter int CLK_PER_TICK  = 100,
    parameter int EXIT_DELAY    = 10,
    parameter int ENTRY_DELAY   = 15,
    parameter int ALARM_TIMEOUT = 60,
    parameter int CNT_W         = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               motion_detected,
    input  logic               push_button,
    output logic               buzzer_signal,
    output logic [2:0]         led_color,
    output logic [STATE_W-1:0] state_code,
    output logic [CNT_W-1:0]   countdown,
    output logic               alarm_event
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (longint'(EXIT_DELAY) > CNT_MAX || EXIT_DELAY < 1) begin : g_chk_exit
        $error("alarm_sequencer: EXIT_DELAY out of range for CNT_W");
    end
    if (longint'(ENTRY_DELAY) > CNT_MAX || ENTRY_DELAY < 1) begin : g_chk_entry
        $error("alarm_sequencer: ENTRY_DELAY out of range for CNT_W");
    end
    if (longint'(ALARM_TIMEOUT) > CNT_MAX || ALARM_TIMEOUT < 1) begin : g_chk_alarm
        $error("alarm_sequencer: ALARM_TIMEOUT out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] EXIT_LD  = CNT_W'(EXIT_DELAY);
    localparam logic [CNT_W-1:0] ENTRY_LD = CNT_W'(ENTRY_DELAY);
`ifdef ALARM_LATCH_EN
    localparam logic [CNT_W-1:0] ALARM_LD = '0;
`else
    localparam logic [CNT_W-1:0] ALARM_LD = CNT_W'(ALARM_TIMEOUT);
`endif
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [1:0]       btn_q;        // [0] latest sample, [1] previous sample
    logic             motion_q;
    logic [CNT_W-1:0] countdown_q, countdown_d;
    logic             buzzer_q, buzzer_d;
    logic [2:0]       led_q, led_d;
    logic             event_q, event_d;

    logic press;
    logic timed;
    logic tick;
    logic expire;
    logic entering;

    assign press    = btn_q[0] & ~btn_q[1];
    assign timed    = (state_q == ST_EXIT_DELAY) || (state_q == ST_ENTRY_DELAY) ||
                      (state_q == ST_ALARM);
    assign expire   = tick && (countdown_q == CNT_ONE);
    assign entering = (state_d != state_q);

    tick_prescaler #(
        .CLK_PER_TICK(CLK_PER_TICK)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clear (entering),
        .enable(timed),
        .tick  (tick)
    );

    // Next-state logic; a press always wins over motion or expiry
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISARMED: begin
                if (press) state_d = ST_EXIT_DELAY;
            end
            ST_EXIT_DELAY: begin
                if (press)       state_d = ST_DISARMED;
                else if (expire) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (press)         state_d = ST_DISARMED;
                else if (motion_q) state_d = ST_ENTRY_DELAY;
            end
            ST_ENTRY_DELAY: begin
                if (press)       state_d = ST_DISARMED;
                else if (expire) state_d = ST_ALARM;
            end
            ST_ALARM: begin
                if (press) state_d = ST_DISARMED;
`ifndef ALARM_LATCH_EN
                else if (expire) state_d = ST_ARMED;
`endif
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    // Countdown: reload on entry, step down per tick, never below 0
    always_comb begin
        countdown_d = countdown_q;
        if (entering) begin
            case (state_d)
                ST_EXIT_DELAY:  countdown_d = EXIT_LD;
                ST_ENTRY_DELAY: countdown_d = ENTRY_LD;
                ST_ALARM:       countdown_d = ALARM_LD;
                default:        countdown_d = '0;
            endcase
        end else if (tick && (countdown_q != '0)) begin
            countdown_d = countdown_q - CNT_ONE;
        end
    end

    // Output values for the coming cycle; delay states chirp one cycle per tick
    always_comb begin
        led_d    = led_for_state(state_d);
        event_d  = (state_d == ST_ALARM) && (state_q != ST_ALARM);
        buzzer_d = (state_d == ST_ALARM) ||
                   (tick && (state_d != ST_DISARMED) &&
                    ((state_q == ST_EXIT_DELAY) || (state_q == ST_ENTRY_DELAY)));
    end

    // State, input history, countdown and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_DISARMED;
            btn_q       <= 2'b00;
            motion_q    <= 1'b0;
            countdown_q <= '0;
            buzzer_q    <= 1'b0;
            led_q       <= LED_GREEN;
            event_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_q       <= {btn_q[0], push_button};
            motion_q    <= motion_detected;
            countdown_q <= countdown_d;
            buzzer_q    <= buzzer_d;
            led_q       <= led_d;
            event_q     <= event_d;
        end
    end

    assign state_code    = state_q;
    assign countdown     = countdown_q;
    assign buzzer_signal = buzzer_q;
    assign led_color     = led_q;
    assign alarm_event   = event_q;

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer with CLK_PER_TICK=4, EXIT_DELAY=3, ENTRY_DELAY=2,
// ALARM_TIMEOUT=5. Scenario tasks queue expected outputs for absolute edge
// numbers; a monitor compares them on the falling edge after that edge.
module tb_alarm_sequencer;

    localparam int CPT   = 4;
    localparam int EXD   = 3;
    localparam int END_D = 2;
    localparam int ATO   = 5;
`ifdef ALARM_LATCH_EN
    localparam logic [7:0] CD_ALARM = 8'd0;
`else
    localparam logic [7:0] CD_ALARM = 8'd5;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       motion = 1'b0;
    logic       button = 1'b0;
    logic       buzzer;
    logic [2:0] led;
    logic [2:0] st;
    logic [7:0] cd;
    logic       ev;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int         c;
        logic [2:0] st;
        logic [7:0] cd;
        logic [2:0] led;
        logic       buz;
        logic       ev;
    } exp_t;
    exp_t sb[$];

    alarm_sequencer #(
        .CLK_PER_TICK (CPT),
        .EXIT_DELAY   (EXD),
        .ENTRY_DELAY  (END_D),
        .ALARM_TIMEOUT(ATO),
        .CNT_W        (8)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .motion_detected(motion),
        .push_button    (button),
        .buzzer_signal  (buzzer),
        .led_color      (led),
        .state_code     (st),
        .countdown      (cd),
        .alarm_event    (ev)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: compare expectations due at the current edge count
    always @(negedge clk) begin
        while (sb.size() != 0 && sb[0].c < cyc) begin
            $display("FAIL stale_expectation cyc %0d was never compared (now %0d)", sb[0].c, cyc);
            vectors++;
            miscompares++;
            void'(sb.pop_front());
        end
        if (sb.size() != 0 && sb[0].c == cyc) begin
            exp_t e;
            e = sb.pop_front();
            vectors += 5;
            if (st !== e.st) begin
                $display("FAIL state_code cyc %0d got %0d want %0d", cyc, st, e.st);
                miscompares++;
            end
            if (cd !== e.cd) begin
                $display("FAIL countdown cyc %0d got %0d want %0d", cyc, cd, e.cd);
                miscompares++;
            end
            if (led !== e.led) begin
                $display("FAIL led_color cyc %0d got %b want %b", cyc, led, e.led);
                miscompares++;
            end
            if (buzzer !== e.buz) begin
                $display("FAIL buzzer_signal cyc %0d got %b want %b", cyc, buzzer, e.buz);
                miscompares++;
            end
            if (ev !== e.ev) begin
                $display("FAIL alarm_event cyc %0d got %b want %b", cyc, ev, e.ev);
                miscompares++;
            end
        end
    end

    task automatic expect_at(input int c, input logic [2:0] s, input logic [7:0] d,
                             input logic [2:0] l, input logic b, input logic e);
        exp_t x;
        x.c = c; x.st = s; x.cd = d; x.led = l; x.buz = b; x.ev = e;
        sb.push_back(x);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (sb.size() != 0) begin
            $display("FAIL drain_timeout got %0d pending want 0", sb.size());
            vectors++;
            miscompares++;
            sb.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; motion = 1'b0; button = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Press and wait for the exit delay to complete (ARMED afterwards)
    task automatic arm();
        @(negedge clk);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors += 5;
        if (st !== 3'd0)     begin $display("FAIL reset_state got %0d want 0", st); miscompares++; end
        if (cd !== 8'd0)     begin $display("FAIL reset_countdown got %0d want 0", cd); miscompares++; end
        if (led !== 3'b010)  begin $display("FAIL reset_led got %b want 010", led); miscompares++; end
        if (buzzer !== 1'b0) begin $display("FAIL reset_buzzer got %b want 0", buzzer); miscompares++; end
        if (ev !== 1'b0)     begin $display("FAIL reset_event got %b want 0", ev); miscompares++; end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_arming();
        int e;
        @(negedge clk);
        e = cyc + 2;
        expect_at(e,      3'd1, 8'd3, 3'b110, 1'b0, 1'b0);
        expect_at(e + 3,  3'd1, 8'd3, 3'b110, 1'b0, 1'b0);
        expect_at(e + 4,  3'd1, 8'd2, 3'b110, 1'b1, 1'b0);
        expect_at(e + 5,  3'd1, 8'd2, 3'b110, 1'b0, 1'b0);
        expect_at(e + 8,  3'd1, 8'd1, 3'b110, 1'b1, 1'b0);
        expect_at(e + 11, 3'd1, 8'd1, 3'b110, 1'b0, 1'b0);
        expect_at(e + 12, 3'd2, 8'd0, 3'b100, 1'b1, 1'b0);
        expect_at(e + 13, 3'd2, 8'd0, 3'b100, 1'b0, 1'b0);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        wait_drain(100);
    endtask

    int t_alarm;

    task automatic test_intrusion();
        int e;
        @(negedge clk);
        e = cyc + 2;
        t_alarm = e + 8;
        expect_at(e,     3'd3, 8'd2, 3'b100, 1'b0, 1'b0);
        expect_at(e + 4, 3'd3, 8'd1, 3'b100, 1'b1, 1'b0);
        expect_at(e + 7, 3'd3, 8'd1, 3'b100, 1'b0, 1'b0);
        expect_at(e + 8, 3'd4, CD_ALARM, 3'b101, 1'b1, 1'b1);
        expect_at(e + 9, 3'd4, CD_ALARM, 3'b101, 1'b1, 1'b0);
        motion = 1'b1;
        wait_until(e);
        motion = 1'b0;
        wait_drain(100);
    endtask

    task automatic test_timeout();
        int a = t_alarm;
`ifdef ALARM_LATCH_EN
        expect_at(a + 20,  3'd4, 8'd0, 3'b101, 1'b1, 1'b0);
        expect_at(a + 100, 3'd4, 8'd0, 3'b101, 1'b1, 1'b0);
        expect_at(a + 102, 3'd0, 8'd0, 3'b010, 1'b0, 1'b0);
        wait_until(a + 100);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        wait_drain(50);
`else
        expect_at(a + 4,  3'd4, 8'd4, 3'b101, 1'b1, 1'b0);
        expect_at(a + 19, 3'd4, 8'd1, 3'b101, 1'b1, 1'b0);
        expect_at(a + 20, 3'd2, 8'd0, 3'b100, 1'b0, 1'b0);
        expect_at(a + 21, 3'd3, 8'd2, 3'b100, 1'b0, 1'b0);
        wait_until(a + 15);
        motion = 1'b1;
        wait_drain(100);
        motion = 1'b0;
`endif
    endtask

    task automatic test_disarm_priority();
        int e;
        do_reset();
        arm();
        @(negedge clk);
        e = cyc + 2;
        expect_at(e,      3'd3, 8'd2, 3'b100, 1'b0, 1'b0);
        expect_at(e + 7,  3'd3, 8'd1, 3'b100, 1'b0, 1'b0);
        expect_at(e + 8,  3'd0, 8'd0, 3'b010, 1'b0, 1'b0);
        expect_at(e + 12, 3'd0, 8'd0, 3'b010, 1'b0, 1'b0);
        motion = 1'b1;
        wait_until(e);
        motion = 1'b0;
        wait_until(e + 6);
        button = 1'b1;
        @(negedge clk);
        button = 1'b0;
        wait_drain(100);
    endtask

    task automatic test_held_button();
        int c0;
        do_reset();
        @(negedge clk);
        c0 = cyc;
        expect_at(c0 + 2,  3'd1, 8'd3, 3'b110, 1'b0, 1'b0);
        expect_at(c0 + 15, 3'd2, 8'd0, 3'b100, 1'b0, 1'b0);
        expect_at(c0 + 40, 3'd2, 8'd0, 3'b100, 1'b0, 1'b0);
        expect_at(c0 + 55, 3'd2, 8'd0, 3'b100, 1'b0, 1'b0);
        button = 1'b1;
        wait_until(c0 + 50);
        button = 1'b0;
        wait_drain(100);
    endtask

    task automatic test_async_reset();
        int c0;
        do_reset();
        arm();
        @(negedge clk);
        c0 = cyc;
        motion = 1'b1;
        wait_until(c0 + 13);
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 5;
        if (st !== 3'd0)     begin $display("FAIL async_state got %0d want 0", st); miscompares++; end
        if (cd !== 8'd0)     begin $display("FAIL async_countdown got %0d want 0", cd); miscompares++; end
        if (led !== 3'b010)  begin $display("FAIL async_led got %b want 010", led); miscompares++; end
        if (buzzer !== 1'b0) begin $display("FAIL async_buzzer got %b want 0", buzzer); miscompares++; end
        if (ev !== 1'b0)     begin $display("FAIL async_event got %b want 0", ev); miscompares++; end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_at(cyc + 2,  3'd0, 8'd0, 3'b010, 1'b0, 1'b0);
        expect_at(cyc + 10, 3'd0, 8'd0, 3'b010, 1'b0, 1'b0);
        wait_drain(50);
        motion = 1'b0;
    endtask

    initial begin
        test_reset();
        test_arming();
        test_intrusion();
        test_timeout();
        test_disarm_priority();
        test_held_button();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Central arm/disarm controller for the home security system; sequences buzzer, status LED and display selection from the PIR motion output and the user push button.
- Implements exit delay, entry delay, alarm and alarm timeout using a seconds-style tick derived from clk.
- Sits between the PIR detector instance and the buzzer/LED/display drivers inside main_system.

Parameters:
- CLK_PER_TICK, 100, clk cycles per countdown tick (must be >= 2).
- EXIT_DELAY, 10, ticks from arming to ARMED (must be >= 1).
- ENTRY_DELAY, 15, ticks from motion to ALARM (must be >= 1).
- ALARM_TIMEOUT, 60, ticks the alarm sounds before auto re-arm (must be >= 1).
- CNT_W, 8, countdown width; every delay parameter must be <= 2^CNT_W-1 (elaboration-time check).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- motion_detected  in  1  level from PIR detector, synchronous to clk.
- push_button  in  1  debounced button level, synchronous to clk.
- buzzer_signal  out  1  buzzer drive.
- led_color  out  3  RGB status LED {R,G,B}.
- state_code  out  3  current state encoding, for the display text mux.
- countdown  out  CNT_W  remaining ticks in the current timed state; 0 otherwise.
- alarm_event  out  1  one-cycle pulse on entry to ALARM.

Behaviour:
- All outputs registered. Reset values: state DISARMED, buzzer_signal 0, led_color 3'b010, state_code 3'd0, countdown 0, alarm_event 0, prescaler 0, button history 0.
- Reset is asserted mid-operation: return to these values immediately (asynchronous), regardless of state.
- Button press = rising edge of push_button: a 1 sampled while the registered previous value is 0. A held button produces exactly one press.
- State encodings: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4.
- Prescaler:
  - Clears on every state entry. Counts 0..CLK_PER_TICK-1 while in EXIT_DELAY, ENTRY_DELAY or ALARM.
  - tick asserts for one cycle when the count equals CLK_PER_TICK-1. The first tick is therefore exactly CLK_PER_TICK cycles after entry.
- Countdown:
  - Loaded with the delay value on state entry. Decrements by 1 on each tick.
  - The transition fires on the tick where countdown == 1, so the state changes exactly N*CLK_PER_TICK cycles after entry.
  - countdown is never observed below 0 and is forced to 0 in DISARMED and ARMED.
- Latency: a qualifying input sampled at edge k is reflected in state and outputs after edge k+1.
- Transitions:
  - DISARMED -> EXIT_DELAY on press.
  - EXIT_DELAY: motion ignored; press -> DISARMED; expiry -> ARMED.
  - ARMED: motion_detected high -> ENTRY_DELAY; press -> DISARMED.
  - ENTRY_DELAY: press -> DISARMED; expiry -> ALARM (countdown loaded with ALARM_TIMEOUT, alarm_event pulses).
  - ALARM: press -> DISARMED; expiry -> ARMED.
- Priority: a press beats motion and beats expiry in the same cycle; the press wins and the other event is dropped.
- Motion held high when re-entering ARMED from ALARM re-triggers ENTRY_DELAY on the next cycle.
- Outputs per state:
  - DISARMED: led 3'b010, buzzer 0.
  - EXIT_DELAY: led 3'b110, buzzer = tick of the previous cycle (one-cycle chirp per tick).
  - ARMED: led 3'b100, buzzer 0.
  - ENTRY_DELAY: led 3'b100, buzzer chirp per tick as in EXIT_DELAY.
  - ALARM: led 3'b101, buzzer 1 continuously.

Optional Feature:
- ALARM_LATCH_EN defined: ALARM never times out. countdown holds 0 and only a press leaves ALARM (to DISARMED).
- ALARM_LATCH_EN undefined: ALARM_TIMEOUT expiry returns to ARMED as specified above.

Decomposition:
- Package alarm_pkg holds the state enum/localparams (0..4), LED color constants (GREEN 3'b010, YELLOW 3'b110, RED 3'b100, MAGENTA 3'b101) and the state_code width.
- One sub-module, tick_prescaler, with ports clk, reset, clear, enable and tick, parameterised by CLK_PER_TICK.
- Edge detect, state machine and countdown stay in alarm_sequencer.

Test Plan (CLK_PER_TICK=4, EXIT_DELAY=3, ENTRY_DELAY=2, ALARM_TIMEOUT=5):
- Arming: reset released, button pulsed 1 cycle -> state_code 1, countdown 3, led 3'b110; 3 chirps; state_code 2, led 3'b100 exactly 12 cycles after entry.
- Intrusion: motion=1 in ARMED -> state_code 3, countdown 2; after 8 cycles state_code 4, alarm_event 1-cycle pulse, buzzer steady 1, led 3'b101.
- Timeout: no button in ALARM -> after 20 cycles state_code 2, buzzer 0. With ALARM_LATCH_EN: still state_code 4 after 100 cycles until a press -> state_code 0.
- Disarm priority: a press on the same cycle countdown reaches 1 with tick in ENTRY_DELAY -> state_code 0, never 4; led 3'b010.
- Held button: push_button held 50 cycles from DISARMED -> exactly one press, ends ARMED (not toggled back to DISARMED).
- Async reset: reset driven 0 mid-ALARM between clock edges -> outputs at reset values immediately; held motion ignored after release (state 0).
